// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer, a registered in_ready,
// synchronous flush and a saturating back-pressure cycle counter.
module pipe_stage_skid #(
  parameter int                  DATA_W      = 64,
  parameter int                  CTRL_W      = 8,
  parameter logic [CTRL_W-1:0]   CTRL_BUBBLE = '0,
  parameter logic [DATA_W-1:0]   PRESET_VAL  = '0,
  parameter int                  STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  input  logic                   stall_clr,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = 1;
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      head_data_q, head_data_d;
  logic [CTRL_W-1:0]      head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0]      skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]      skid_ctrl_q, skid_ctrl_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      state_d     = ST_EMPTY;
      head_ctrl_d = CTRL_BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            head_data_d = in_data;
            head_ctrl_d = in_ctrl;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            head_data_d = in_data;
            head_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = ST_FULL;
          end else if (out_fire) begin
            // Head control goes to the nop encoding as soon as the stage empties.
            head_ctrl_d = CTRL_BUBBLE;
            state_d     = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
            state_d     = ST_ONE;
          end
        end
        default: begin
          head_ctrl_d = CTRL_BUBBLE;
          state_d     = ST_EMPTY;
        end
      endcase
    end

    // Handshake outputs are decoded from the next state so both leave flops directly.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_ONE;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_EMPTY;
      head_data_q <= PRESET_VAL;
      head_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= PRESET_VAL;
      skid_ctrl_q <= CTRL_BUBBLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_data_q;
  assign out_ctrl  = head_ctrl_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random checks of pipe_stage_skid against a queue-based reference FIFO.
`timescale 1ns/1ps
module tb_pipe_stage_skid;

  localparam int             DW  = 16;
  localparam int             CW  = 8;
  localparam int             SW  = 4;
  localparam logic [CW-1:0]  BUB = 8'hA5;
  localparam logic [DW-1:0]  PRE = 16'h1234;

  logic          clk;
  logic          arst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          stall_clr;
  logic [SW-1:0] stall_cnt;

  pipe_stage_skid #(
    .DATA_W      (DW),
    .CTRL_W      (CW),
    .CTRL_BUBBLE (BUB),
    .PRESET_VAL  (PRE),
    .STALL_CNT_W (SW)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t q[$];
  int   m_stall = 0;
  int   total   = 0;
  int   bad     = 0;
  bit   verbose = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    ent_t h;
    bit   of;
    bit   inf;
    @(negedge clk);
    check("out_valid", out_valid, 32'(q.size() != 0));
    check("in_ready", in_ready, 32'(q.size() != 2));
    check("stall_cnt", stall_cnt, m_stall);
    if (q.size() != 0) begin
      h = q[0];
      check("out_data", out_data, h.d);
      check("out_ctrl", out_ctrl, h.c);
    end else begin
      check("bubble_ctrl", out_ctrl, BUB);
    end
    of  = (q.size() != 0) && out_ready;
    inf = in_valid && (q.size() != 2);
    if (stall_clr) m_stall = 0;
    else if ((q.size() != 0) && !out_ready && (m_stall != 15)) m_stall++;
    if (flush) begin
      if (verbose) $display("flush: dropped %0d entries", q.size());
      q.delete();
    end else begin
      if (of) begin
        if (verbose) $display("xfer out: data=%0h ctrl=%0h", out_data, out_ctrl);
        void'(q.pop_front());
      end
      if (inf) q.push_back('{d: in_data, c: in_ctrl});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    stall_clr = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, PRE);
    check("rst_out_ctrl", out_ctrl, BUB);
    check("rst_stall_cnt", stall_cnt, 0);
    #1 arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      in_ctrl  = CW'(i + 8'h10);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // Stall fill with A, B then drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 16'hAAAA; in_ctrl = 8'h0A; cycle();
    in_data = 16'hBBBB; in_ctrl = 8'h0B; cycle();
    in_valid = 1'b0;
    cycle();
    check("fill_in_ready", in_ready, 0);
    check("fill_head", out_data, 16'hAAAA);
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();
    check("drain_empty", out_valid, 0);

    // Flush while FULL with a valid input C
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 16'h1111; in_ctrl = 8'h01; cycle();
    in_data = 16'h2222; in_ctrl = 8'h02; cycle();
    check("pre_flush_full", in_ready, 0);
    flush = 1'b1;
    in_data = 16'hCCCC; in_ctrl = 8'h0C;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_ctrl", out_ctrl, BUB);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Stall counter saturation and clear
    stall_clr = 1'b1;
    cycle();
    stall_clr = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 16'h4444; in_ctrl = 8'h44;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check("stall_sat", stall_cnt, 15);
    stall_clr = 1'b1;
    cycle();
    stall_clr = 1'b0;
    check("stall_clr", stall_cnt, 0);

    // Asynchronous reset while FULL
    in_valid = 1'b1;
    in_data = 16'h5555; in_ctrl = 8'h55;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("pre_arst_full", in_ready, 0);
    arst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_stall_cnt", stall_cnt, 0);
    check("arst_out_ctrl", out_ctrl, BUB);
    check("arst_out_data", out_data, PRE);
    q.delete();
    m_stall = 0;
    #1 arst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(16'h6000 + i);
      in_ctrl  = CW'(8'h60 + i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // Random traffic against the reference FIFO
    verbose = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = DW'($urandom);
      in_ctrl   = CW'($urandom);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
